// File: rtl/rot_shift_arb.sv
// rot_shift_arb: two-requester round-robin front end for a shared 32-bit
// rotate-right unit. ROR/ROL/SRL/SLL/SRA are derived from the single rotator
// by remapping the amount and masking. The result is registered behind a
// valid/ready response port.
// Optional feature macro: ROT_SHIFT_STICKY_EN adds rsp_sticky (OR of the bits
// shifted out by SRL/SRA).

module rot_shift_arb #(
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_amt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_amt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
`ifdef ROT_SHIFT_STICKY_EN
  output logic        rsp_sticky,
`endif
  output logic [31:0] rsp_data
);

  localparam logic [2:0] OpRor = 3'b000;
  localparam logic [2:0] OpRol = 3'b001;
  localparam logic [2:0] OpSrl = 3'b010;
  localparam logic [2:0] OpSll = 3'b011;
  localparam logic [2:0] OpSra = 3'b100;

  logic        ptr_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_data_q;

  logic        grant0;
  logic        grant1;
  logic        can_load;
  logic        accept;
  logic        sel_id;
  logic [2:0]  sel_op;
  logic [31:0] sel_data;
  logic [4:0]  sel_amt;
  logic [4:0]  rot_amt;
  logic [63:0] rot_wide;
  logic [31:0] lps_r;
  logic [31:0] mask_r;
  logic [31:0] mask_l;
  logic [31:0] result;

  // Arbitration and handshake; readies are forced low while reset is asserted.
  always_comb begin
    grant0   = req0_valid && (!req1_valid || !ptr_q);
    grant1   = req1_valid && (!req0_valid || ptr_q);
    can_load = !rsp_valid_q || rsp_ready;
    req0_ready = rst_n && grant0 && can_load;
    req1_ready = rst_n && grant1 && can_load;
    accept   = req0_ready || req1_ready;
    sel_id   = grant1;
  end

  // Operand mux, amount remap and the shared rotator with op-specific masking.
  always_comb begin
    sel_op   = grant1 ? req1_op   : req0_op;
    sel_data = grant1 ? req1_data : req0_data;
    sel_amt  = grant1 ? req1_amt  : req0_amt;
    // Left-going ops rotate right by (32 - amt) mod 32.
    rot_amt  = ((sel_op == OpRol) || (sel_op == OpSll)) ? (5'd0 - sel_amt) : sel_amt;
    rot_wide = {sel_data, sel_data} >> rot_amt;
    lps_r    = rot_wide[31:0];
    mask_r   = 32'hFFFF_FFFF >> sel_amt;
    mask_l   = 32'hFFFF_FFFF << sel_amt;
    result   = sel_data;
    case (sel_op)
      OpRor, OpRol: result = lps_r;
      OpSrl:        result = lps_r & mask_r;
      OpSll:        result = lps_r & mask_l;
      OpSra:        result = (lps_r & mask_r) | (sel_data[31] ? ~mask_r : 32'h0);
      default:      result = sel_data;
    endcase
  end

  // Response register and priority pointer; the served requester loses the next conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= PRIO_INIT[0];
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else if (accept) begin
      ptr_q       <= ~sel_id;
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= sel_id;
      rsp_data_q  <= result;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

`ifdef ROT_SHIFT_STICKY_EN
  logic sticky_d;
  logic sticky_q;

  // Sticky is the OR of the low amt bits dropped by right shifts.
  always_comb begin
    sticky_d = 1'b0;
    if ((sel_op == OpSrl) || (sel_op == OpSra)) begin
      sticky_d = |(sel_data & ~mask_l);
    end
  end

  // Sticky register loads alongside the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (accept) begin
      sticky_q <= sticky_d;
    end
  end

  assign rsp_sticky = sticky_q;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
